mux41_sum_seq: RTL

Sequencer that sits directly around the 4-bit 4:1 select mux in the 4-bit adder datapath: upstream it loads four 4-bit operands and drives the mux's `a`/`b`/`c`/`d`/`sel` inputs; downstream it consumes the mux output `y` and accumulates it. One run steps `sel` through 00..11, one value per cycle, adds each selected value into a widened accumulator, and reports the total with a one-cycle `done` pulse. The bench instantiates the real mux between `sel`/`a..d` and `y_in`.

---
 rtl/mux41_sum_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/mux41_sum_seq.sv
// mux41_sum_seq: loads four operands, steps a 4:1 mux select through them and
// accumulates the mux output into a widened sum reported with a done pulse.
module mux41_sum_seq #(
  parameter int W  = 4,
  parameter int SW = W + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          start,
  output logic          busy,
  output logic [1:0]    sel,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic [W-1:0]  c,
  output logic [W-1:0]  d,
  input  logic [W-1:0]  y_in,
  output logic [SW-1:0] sum,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] wptr_q, wptr_d, sel_q, sel_d;
  logic loaded_q, loaded_d, done_q, done_d;
  logic [SW-1:0] acc_q, acc_d, sum_q, sum_d, y_ext;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic wr;
  assign in_ready = (state_q == IDLE) && !loaded_q;
  assign busy     = state_q == RUN;
  assign wr       = in_valid && in_ready;
  assign y_ext    = {{(SW-W){1'b0}}, y_in};
  assign sel  = sel_q;
  assign a    = a_q;
  assign b    = b_q;
  assign c    = c_q;
  assign d    = d_q;
  assign sum  = sum_q;
  assign done = done_q;
  always_comb begin
    state_d  = state_q;
    wptr_d   = wr ? wptr_q + 2'd1 : wptr_q;
    loaded_d = loaded_q || (wr && wptr_q == 2'd3);
    a_d      = (wr && wptr_q == 2'd0) ? in_data : a_q;
    b_d      = (wr && wptr_q == 2'd1) ? in_data : b_q;
    c_d      = (wr && wptr_q == 2'd2) ? in_data : c_q;
    d_d      = (wr && wptr_q == 2'd3) ? in_data : d_q;
    sel_d    = sel_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = 2'd0;
        if (start && loaded_q) begin
          state_d = RUN;
          acc_d   = '0;
        end
      end
      RUN: begin
        acc_d = acc_q + y_ext;
        sel_d = sel_q + 2'd1;
        if (sel_q == 2'd3) begin
          sum_d   = acc_q + y_ext;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        loaded_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      loaded_q <= 1'b0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      sel_q    <= '0;
      sum_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      loaded_q <= loaded_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      sel_q    <= sel_d;
      sum_q    <= sum_d;
      done_q   <= done_d;
    end
  end
endmodule
